// File: rtl/rx_fsrc_en_ctrl_if.sv
// rtl/rx_fsrc_en_ctrl_if.sv - mode request, sample valid and status bundle for the FSRC enable sequencer
interface rx_fsrc_en_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_enable;
  logic                 in_valid;
  logic                 dp_in_valid;
  logic                 fsrc_en;
  logic                 busy;
  logic                 switch_done;
  logic [CNT_WIDTH-1:0] switch_count;
  logic [CNT_WIDTH-1:0] drop_count;

  modport master (
    output cfg_enable,
    output in_valid,
    input  dp_in_valid,
    input  fsrc_en,
    input  busy,
    input  switch_done,
    input  switch_count,
    input  drop_count
  );

  modport slave (
    input  cfg_enable,
    input  in_valid,
    output dp_in_valid,
    output fsrc_en,
    output busy,
    output switch_done,
    output switch_count,
    output drop_count
  );
endinterface

// File: rtl/rx_fsrc_en_ctrl.sv
// rtl/rx_fsrc_en_ctrl.sv - drains the removal pipeline before flipping fsrc_en; RX_FSRC_EN_CTRL_DROP_CNT_EN adds a saturating drop counter
module rx_fsrc_en_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input logic               clk,
  input logic               resetn,
  rx_fsrc_en_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DRAIN_ON,
    ST_ON,
    ST_DRAIN_OFF
  } state_t;

  localparam logic [7:0]           DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 fsrc_q, fsrc_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] sw_q, sw_d;
  logic                 draining;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OFF;
      cnt_q   <= 8'd0;
      fsrc_q  <= 1'b0;
      done_q  <= 1'b0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fsrc_q  <= fsrc_d;
      done_q  <= done_d;
      sw_q    <= sw_d;
    end
  end

  // A request seen in a drain state is ignored; it is re-evaluated once settled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fsrc_d  = fsrc_q;
    done_d  = 1'b0;
    sw_d    = sw_q;
    case (state_q)
      ST_OFF: begin
        if (bus.cfg_enable) begin
          state_d = ST_DRAIN_ON;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_ON: begin
        if (!bus.cfg_enable) begin
          state_d = ST_DRAIN_OFF;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN_ON: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_ON;
          fsrc_d  = 1'b1;
          done_d  = 1'b1;
          sw_d    = sw_q + CNT_ONE;
        end
      end
      ST_DRAIN_OFF: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_OFF;
          fsrc_d  = 1'b0;
          done_d  = 1'b1;
          sw_d    = sw_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = 8'd0;
        fsrc_d  = 1'b0;
      end
    endcase
  end

  assign draining         = (state_q == ST_DRAIN_ON) || (state_q == ST_DRAIN_OFF);
  assign bus.busy         = draining;
  assign bus.dp_in_valid  = bus.in_valid && !draining;
  assign bus.fsrc_en      = fsrc_q;
  assign bus.switch_done  = done_q;
  assign bus.switch_count = sw_q;

`ifdef RX_FSRC_EN_CTRL_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_q <= '0;
    end else if (bus.in_valid && draining && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_ONE;
    end
  end

  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_rx_fsrc_en_ctrl.sv
// tb/tb_rx_fsrc_en_ctrl.sv - scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor compares
module tb_rx_fsrc_en_ctrl;

  localparam int DRAIN = 4;
  localparam int CW    = 4;

  typedef struct {
    logic          dp;
    logic          fsrc;
    logic          busy;
    logic          done;
    logic [CW-1:0] sw;
    logic [CW-1:0] drop;
    string         tag;
  } exp_t;

  logic clk;
  logic resetn;

  rx_fsrc_en_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  rx_fsrc_en_ctrl #(
    .DRAIN_CYCLES(DRAIN),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  exp_t          exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  string         phase       = "reset";
  bit            cur_mode    = 1'b0;
  bit            pend        = 1'b0;
  logic [CW-1:0] exp_sw      = '0;
  logic [CW-1:0] exp_drop    = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want stimulus to finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (bus.dp_in_valid !== e.dp || bus.fsrc_en !== e.fsrc || bus.busy !== e.busy ||
          bus.switch_done !== e.done || bus.switch_count !== e.sw || bus.drop_count !== e.drop) begin
        miscompares++;
        $display("FAIL %s: got dp=%b fsrc=%b busy=%b done=%b sw=%0d drop=%0d, want dp=%b fsrc=%b busy=%b done=%b sw=%0d drop=%0d",
                 e.tag, bus.dp_in_valid, bus.fsrc_en, bus.busy, bus.switch_done, bus.switch_count,
                 bus.drop_count, e.dp, e.fsrc, e.busy, e.done, e.sw, e.drop);
      end
    end else if (bus.switch_done === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_switch_done: got done=1, want no pulse");
    end
  end

  // One clock cycle: inputs driven after the edge, expected outputs for that cycle pushed.
  task automatic cyc(input bit rn, input bit late_rst, input bit cfg, input bit iv,
                     input bit e_dp, input bit e_fsrc, input bit e_busy, input bit e_done);
    exp_t e;
    @(posedge clk);
    #1;
    if (resetn && pend) begin
`ifdef RX_FSRC_EN_CTRL_DROP_CNT_EN
      if (exp_drop != '1) exp_drop = exp_drop + 1'b1;
`endif
    end
    bus.cfg_enable = cfg;
    bus.in_valid   = iv;
    resetn         = rn;
    if (e_done) exp_sw = exp_sw + 1'b1;
    e.dp   = e_dp;
    e.fsrc = e_fsrc;
    e.busy = e_busy;
    e.done = e_done;
    e.sw   = exp_sw;
    e.drop = exp_drop;
    e.tag  = phase;
    pend   = e_busy && iv && rn;
    if (late_rst) begin
      #2;
      resetn = 1'b0;
    end
    if (!rn || late_rst) begin
      exp_sw   = '0;
      exp_drop = '0;
      pend     = 1'b0;
      cur_mode = 1'b0;
      e.dp     = iv;
      e.fsrc   = 1'b0;
      e.busy   = 1'b0;
      e.done   = 1'b0;
      e.sw     = '0;
      e.drop   = '0;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit iv);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, cur_mode, iv, iv, cur_mode, 1'b0, 1'b0);
  endtask

  task automatic request(input bit m);
    cyc(1'b1, 1'b0, m, 1'b1, 1'b1, cur_mode, 1'b0, 1'b0);
  endtask

  // cfg_enable holds the target for drain cycles before flip_at, then the opposite value.
  task automatic drain(input bit m, input int flip_at, input bit iv);
    for (int i = 0; i < DRAIN; i++)
      cyc(1'b1, 1'b0, (i < flip_at) ? m : !m, iv, 1'b0, cur_mode, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, (flip_at <= DRAIN) ? !m : m, 1'b1, 1'b1, m, 1'b0, 1'b1);
    cur_mode = m;
  endtask

  initial begin
    resetn         = 1'b0;
    bus.cfg_enable = 1'b0;
    bus.in_valid   = 1'b0;

    phase = "reset_state";
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    phase = "idle_off_valid";
    idle(20, 1'b1);
    phase = "idle_off_novalid";
    idle(3, 1'b0);

    phase = "enable_drain";
    request(1'b1);
    drain(1'b1, DRAIN + 1, 1'b1);
    phase = "idle_on";
    idle(3, 1'b1);

    phase = "disable_drain";
    request(1'b0);
    drain(1'b0, DRAIN + 1, 1'b1);
    idle(3, 1'b1);

    phase = "toggle_back";
    request(1'b1);
    drain(1'b1, 1, 1'b1);
    drain(1'b0, DRAIN + 1, 1'b1);
    idle(3, 1'b1);

    phase = "reset_mid_drain";
    request(1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.cfg_enable = 1'b0;
    phase = "after_reset";
    idle(3, 1'b1);

    phase = "drain_no_valid";
    request(1'b1);
    drain(1'b1, DRAIN + 1, 1'b0);
    request(1'b0);
    drain(1'b0, DRAIN + 1, 1'b0);

    phase = "drop_saturate";
    for (int k = 0; k < 5; k++) begin
      request(1'b1);
      drain(1'b1, DRAIN + 1, 1'b1);
      request(1'b0);
      drain(1'b0, DRAIN + 1, 1'b1);
    end

    phase = "switch_wrap";
    for (int k = 0; k < 2; k++) begin
      request(1'b1);
      drain(1'b1, DRAIN + 1, 1'b1);
      request(1'b0);
      drain(1'b0, DRAIN + 1, 1'b1);
    end
    idle(2, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_queue: got %0d pending expectations, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
